// File: rtl/axi_burst_master_if.sv
// AXI4 channel bundle between axi_burst_master and an interconnect/slave.
//   AR: ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID (master out), ARREADY (master in)
//   R : RID, RDATA, RRESP, RLAST, RVALID (master in), RREADY (master out)
//   AW: AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID (master out), AWREADY (master in)
//   W : WDATA, WSTRB, WLAST, WVALID (master out), WREADY (master in)
//   B : BID, BRESP, BVALID (master in), BREADY (master out)
interface axi_burst_master_if #(
    parameter int unsigned ID_BITS   = 4,
    parameter int unsigned ADDR_BITS = 32,
    parameter int unsigned DATA_BITS = 32
);
    // AR channel
    logic [ID_BITS-1:0]     ARID;
    logic [ADDR_BITS-1:0]   ARADDR;
    logic [3:0]             ARLEN;
    logic [2:0]             ARSIZE;
    logic [1:0]             ARBURST;
    logic                   ARVALID;
    logic                   ARREADY;
    // R channel
    logic [ID_BITS-1:0]     RID;
    logic [DATA_BITS-1:0]   RDATA;
    logic [1:0]             RRESP;
    logic                   RLAST;
    logic                   RVALID;
    logic                   RREADY;
    // AW channel
    logic [ID_BITS-1:0]     AWID;
    logic [ADDR_BITS-1:0]   AWADDR;
    logic [3:0]             AWLEN;
    logic [2:0]             AWSIZE;
    logic [1:0]             AWBURST;
    logic                   AWVALID;
    logic                   AWREADY;
    // W channel
    logic [DATA_BITS-1:0]   WDATA;
    logic [DATA_BITS/8-1:0] WSTRB;
    logic                   WLAST;
    logic                   WVALID;
    logic                   WREADY;
    // B channel
    logic [ID_BITS-1:0]     BID;
    logic [1:0]             BRESP;
    logic                   BVALID;
    logic                   BREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY,
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY,
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );
endinterface

// File: rtl/axi_burst_master.sv
// Cache-side AXI4 master: line reads as an INCR burst of BURST_LEN beats, single-beat writes.
// One transaction outstanding at a time.
//   clk, rst            : clock (rising edge), synchronous active-low reset
//   req_*               : request from the cache (valid/ready, write flag, addr, wdata, wstrb)
//   rsp_*               : response beats back to the cache (data, beat index, last, error)
//   axi (master modport): AR/R/AW/W/B channels
// All outputs are registered; the FSM and every output flop live in one always_ff.
module axi_burst_master #(
    parameter int unsigned ID_BITS   = 4,
    parameter int unsigned ADDR_BITS = 32,
    parameter int unsigned DATA_BITS = 32,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned MASTER_ID = 0
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_BITS-1:0]   req_addr,
    input  logic [DATA_BITS-1:0]   req_wdata,
    input  logic [DATA_BITS/8-1:0] req_wstrb,

    output logic                   rsp_valid,
    output logic [DATA_BITS-1:0]   rsp_data,
    output logic [3:0]             rsp_beat,
    output logic                   rsp_last,
    output logic                   rsp_err,

    axi_burst_master_if.master     axi
);

    localparam int unsigned BYTES      = DATA_BITS / 8;
    localparam int unsigned LINE_SHIFT = $clog2(BURST_LEN * BYTES);

    localparam logic [ADDR_BITS-1:0] LINE_MASK = {ADDR_BITS{1'b1}} << LINE_SHIFT;
    localparam logic [3:0]           LAST_BEAT = 4'(BURST_LEN - 1);
    localparam logic [2:0]           AXI_SIZE  = 3'($clog2(BYTES));
    localparam logic [1:0]           BURST_INC = 2'b01;
    localparam logic [ID_BITS-1:0]   OWN_ID    = ID_BITS'(MASTER_ID);

    typedef enum logic [2:0] {StIdle, StAr, StR, StW, StB} state_e;

    state_e                 state_q,     state_d;
    logic                   req_ready_q, req_ready_d;

    logic                   rsp_valid_q, rsp_valid_d;
    logic [DATA_BITS-1:0]   rsp_data_q,  rsp_data_d;
    logic [3:0]             rsp_beat_q,  rsp_beat_d;
    logic                   rsp_last_q,  rsp_last_d;
    logic                   rsp_err_q,   rsp_err_d;

    logic [3:0]             beat_q,      beat_d;
    logic                   err_acc_q,   err_acc_d;

    logic [ID_BITS-1:0]     arid_q,      arid_d;
    logic [ADDR_BITS-1:0]   araddr_q,    araddr_d;
    logic [3:0]             arlen_q,     arlen_d;
    logic [2:0]             arsize_q,    arsize_d;
    logic [1:0]             arburst_q,   arburst_d;
    logic                   arvalid_q,   arvalid_d;
    logic                   rready_q,    rready_d;

    logic [ID_BITS-1:0]     awid_q,      awid_d;
    logic [ADDR_BITS-1:0]   awaddr_q,    awaddr_d;
    logic [3:0]             awlen_q,     awlen_d;
    logic [2:0]             awsize_q,    awsize_d;
    logic [1:0]             awburst_q,   awburst_d;
    logic                   awvalid_q,   awvalid_d;

    logic [DATA_BITS-1:0]   wdata_q,     wdata_d;
    logic [DATA_BITS/8-1:0] wstrb_q,     wstrb_d;
    logic                   wlast_q,     wlast_d;
    logic                   wvalid_q,    wvalid_d;

    logic                   bready_q,    bready_d;

    // Per-beat read error terms.
    logic                   r_hs;
    logic                   r_final;
    logic                   r_beat_err;

    assign r_hs       = axi.RVALID && rready_q;
    assign r_final    = (beat_q == LAST_BEAT);
    // RLAST must appear exactly on the final beat: early is an error, missing is an error.
    assign r_beat_err = (axi.RRESP != 2'b00) || (axi.RID != OWN_ID) ||
                        (axi.RLAST != r_final);

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_beat_d  = rsp_beat_q;
        rsp_last_d  = 1'b0;
        rsp_err_d   = 1'b0;
        beat_d      = beat_q;
        err_acc_d   = err_acc_q;
        arid_d      = arid_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        arsize_d    = arsize_q;
        arburst_d   = arburst_q;
        arvalid_d   = arvalid_q;
        awid_d      = awid_q;
        awaddr_d    = awaddr_q;
        awlen_d     = awlen_q;
        awsize_d    = awsize_q;
        awburst_d   = awburst_q;
        awvalid_d   = awvalid_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        wlast_d     = wlast_q;
        wvalid_d    = wvalid_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready_q) begin
                    if (!req_write) begin
                        arid_d    = OWN_ID;
                        araddr_d  = req_addr & LINE_MASK;
                        arlen_d   = LAST_BEAT;
                        arsize_d  = AXI_SIZE;
                        arburst_d = BURST_INC;
                        arvalid_d = 1'b1;
                        state_d   = StAr;
                    end else if (req_wstrb != '0) begin
                        awid_d    = OWN_ID;
                        awaddr_d  = req_addr;
                        awlen_d   = 4'd0;
                        awsize_d  = AXI_SIZE;
                        awburst_d = BURST_INC;
                        awvalid_d = 1'b1;
                        wdata_d   = req_wdata;
                        wstrb_d   = req_wstrb;
                        wlast_d   = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = StW;
                    end else begin
                        // Empty write: nothing to put on the bus, complete locally.
                        rsp_valid_d = 1'b1;
                        rsp_last_d  = 1'b1;
                        rsp_beat_d  = 4'd0;
                    end
                end
            end

            StAr: begin
                if (axi.ARREADY) begin
                    arvalid_d = 1'b0;
                    beat_d    = 4'd0;
                    err_acc_d = 1'b0;
                    state_d   = StR;
                end
            end

            StR: begin
                if (r_hs) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = axi.RDATA;
                    rsp_beat_d  = beat_q;
                    beat_d      = beat_q + 4'd1;
                    err_acc_d   = err_acc_q | r_beat_err;
                    // The burst ends by beat count, regardless of RLAST.
                    if (r_final) begin
                        rsp_last_d = 1'b1;
                        rsp_err_d  = err_acc_q | r_beat_err;
                        state_d    = StIdle;
                    end
                end
            end

            StW: begin
                // Each valid drops on its own handshake; both may complete in one cycle.
                if (axi.AWREADY) awvalid_d = 1'b0;
                if (axi.WREADY)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) state_d = StB;
            end

            StB: begin
                if (axi.BVALID && bready_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = 1'b1;
                    rsp_beat_d  = 4'd0;
                    rsp_err_d   = (axi.BRESP != 2'b00) || (axi.BID != OWN_ID);
                    state_d     = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // Ready outputs are registered copies of the next state decode, so they are 0 in reset.
    assign req_ready_d = (state_d == StIdle);
    assign rready_d    = (state_d == StR);
    assign bready_d    = (state_d == StB);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_beat_q  <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            beat_q      <= '0;
            err_acc_q   <= 1'b0;
            arid_q      <= '0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            arsize_q    <= '0;
            arburst_q   <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awid_q      <= '0;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            awsize_q    <= '0;
            awburst_q   <= '0;
            awvalid_q   <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wlast_q     <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_beat_q  <= rsp_beat_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
            beat_q      <= beat_d;
            err_acc_q   <= err_acc_d;
            arid_q      <= arid_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            arsize_q    <= arsize_d;
            arburst_q   <= arburst_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awid_q      <= awid_d;
            awaddr_q    <= awaddr_d;
            awlen_q     <= awlen_d;
            awsize_q    <= awsize_d;
            awburst_q   <= awburst_d;
            awvalid_q   <= awvalid_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            wlast_q     <= wlast_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_beat    = rsp_beat_q;
    assign rsp_last    = rsp_last_q;
    assign rsp_err     = rsp_err_q;

    assign axi.ARID    = arid_q;
    assign axi.ARADDR  = araddr_q;
    assign axi.ARLEN   = arlen_q;
    assign axi.ARSIZE  = arsize_q;
    assign axi.ARBURST = arburst_q;
    assign axi.ARVALID = arvalid_q;
    assign axi.RREADY  = rready_q;
    assign axi.AWID    = awid_q;
    assign axi.AWADDR  = awaddr_q;
    assign axi.AWLEN   = awlen_q;
    assign axi.AWSIZE  = awsize_q;
    assign axi.AWBURST = awburst_q;
    assign axi.AWVALID = awvalid_q;
    assign axi.WDATA   = wdata_q;
    assign axi.WSTRB   = wstrb_q;
    assign axi.WLAST   = wlast_q;
    assign axi.WVALID  = wvalid_q;
    assign axi.BREADY  = bready_q;

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master (default parameters: 32-bit data, 4-beat lines).
module tb_axi_burst_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_beat;
    logic        rsp_last;
    logic        rsp_err;

    int checks   = 0;
    int failures = 0;

    // Captures from the last read_burst call.
    logic [31:0] cap_araddr;
    logic [3:0]  cap_arlen;
    logic        cap_arvalid_hold;
    logic [31:0] cap_araddr_hold;
    logic        cap_rready;
    logic        cap_valid [4];
    logic [31:0] cap_data  [4];
    logic [3:0]  cap_beat  [4];
    logic        cap_last  [4];
    logic        cap_err   [4];
    logic        cap_ready_after;

    axi_burst_master_if #(.ID_BITS(4), .ADDR_BITS(32), .DATA_BITS(32)) axi ();

    axi_burst_master #(
        .ID_BITS   (4),
        .ADDR_BITS (32),
        .DATA_BITS (32),
        .BURST_LEN (4),
        .MASTER_ID (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_beat  (rsp_beat),
        .rsp_last  (rsp_last),
        .rsp_err   (rsp_err),
        .axi       (axi.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_slave();
        axi.ARREADY = 1'b0;
        axi.RID = '0; axi.RDATA = '0; axi.RRESP = '0; axi.RLAST = 1'b0; axi.RVALID = 1'b0;
        axi.AWREADY = 1'b0;
        axi.WREADY = 1'b0;
        axi.BID = '0; axi.BRESP = '0; axi.BVALID = 1'b0;
    endtask

    // Drives one line read; err_beat gets RRESP=10, RLAST on rlast_beat (-1 = never).
    task automatic read_burst(input logic [31:0] addr, input int ar_delay,
                              input int err_beat, input int rlast_beat);
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
        tick();
        req_valid = 1'b0;
        cap_araddr = axi.ARADDR;
        cap_arlen  = axi.ARLEN;
        repeat (ar_delay) tick();
        cap_arvalid_hold = axi.ARVALID;
        cap_araddr_hold  = axi.ARADDR;
        axi.ARREADY = 1'b1;
        tick();
        axi.ARREADY = 1'b0;
        cap_rready = axi.RREADY;
        for (int i = 0; i < 4; i++) begin
            axi.RVALID = 1'b1;
            axi.RDATA  = 32'hA0 + 32'(i);
            axi.RID    = '0;
            axi.RRESP  = (i == err_beat) ? 2'b10 : 2'b00;
            axi.RLAST  = (i == rlast_beat);
            tick();
            cap_valid[i] = rsp_valid; cap_data[i] = rsp_data; cap_beat[i] = rsp_beat;
            cap_last[i]  = rsp_last;  cap_err[i]  = rsp_err;
        end
        axi.RVALID = 1'b0; axi.RLAST = 1'b0; axi.RRESP = '0;
        cap_ready_after = req_ready;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_slave();
        tick(); tick();
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready got=%0b exp=0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%0b exp=0", rsp_valid); end
        checks++; if ({axi.ARVALID, axi.AWVALID, axi.WVALID, axi.RREADY, axi.BREADY} !== 5'b0) begin
            failures++; $display("FAIL rst_axi_handshake got=%05b exp=00000",
                {axi.ARVALID, axi.AWVALID, axi.WVALID, axi.RREADY, axi.BREADY});
        end
        checks++; if (axi.ARADDR !== 32'h0) begin failures++; $display("FAIL rst_araddr got=%h exp=0", axi.ARADDR); end
        rst = 1'b1;
        tick();
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready got=%0b exp=1", req_ready); end
    endtask

    task automatic test_read_basic();
        read_burst(32'h1000_0014, 2, -1, 3);
        checks++; if (cap_araddr !== 32'h1000_0010) begin failures++; $display("FAIL rd_araddr got=%h exp=10000010", cap_araddr); end
        checks++; if (cap_arlen !== 4'd3) begin failures++; $display("FAIL rd_arlen got=%0d exp=3", cap_arlen); end
        checks++; if (axi.ARSIZE !== 3'd2 || axi.ARBURST !== 2'b01 || axi.ARID !== 4'd0) begin
            failures++; $display("FAIL rd_arctl got=size%0d burst%0d id%0d exp=size2 burst1 id0",
                axi.ARSIZE, axi.ARBURST, axi.ARID);
        end
        checks++; if (cap_arvalid_hold !== 1'b1 || cap_araddr_hold !== 32'h1000_0010) begin
            failures++; $display("FAIL rd_ar_hold got=%0b/%h exp=1/10000010", cap_arvalid_hold, cap_araddr_hold);
        end
        checks++; if (cap_rready !== 1'b1) begin failures++; $display("FAIL rd_rready got=%0b exp=1", cap_rready); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_valid[i] !== 1'b1 || cap_data[i] !== 32'hA0 + 32'(i) || cap_beat[i] !== 4'(i) ||
                cap_last[i] !== (i == 3)) begin
                failures++; $display("FAIL rd_beat%0d got=v%0b d%h b%0d l%0b exp=v1 d%h b%0d l%0b", i,
                    cap_valid[i], cap_data[i], cap_beat[i], cap_last[i], 32'hA0 + 32'(i), i, (i == 3));
            end
        end
        checks++; if (cap_err[3] !== 1'b0) begin failures++; $display("FAIL rd_err got=%0b exp=0", cap_err[3]); end
        checks++; if (cap_ready_after !== 1'b1) begin failures++; $display("FAIL rd_ready_after got=%0b exp=1", cap_ready_after); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rd_rsp_drop got=%0b exp=0", rsp_valid); end
    endtask

    task automatic test_read_rresp_err();
        read_burst(32'h0000_0040, 0, 1, 3);
        checks++; if (cap_valid[0] & cap_valid[1] & cap_valid[2] & cap_valid[3] !== 1'b1) begin
            failures++; $display("FAIL rresp_beats got=%0b%0b%0b%0b exp=1111",
                cap_valid[0], cap_valid[1], cap_valid[2], cap_valid[3]);
        end
        checks++; if (cap_last[3] !== 1'b1 || cap_err[3] !== 1'b1) begin
            failures++; $display("FAIL rresp_err got=l%0b e%0b exp=l1 e1", cap_last[3], cap_err[3]);
        end
    endtask

    task automatic test_read_early_rlast();
        read_burst(32'h0000_0080, 1, -1, 2);
        checks++; if (cap_last[2] !== 1'b0 || cap_last[3] !== 1'b1) begin
            failures++; $display("FAIL early_rlast_last got=%0b%0b exp=01", cap_last[2], cap_last[3]);
        end
        checks++; if (cap_err[3] !== 1'b1) begin failures++; $display("FAIL early_rlast_err got=%0b exp=1", cap_err[3]); end
        read_burst(32'h0000_00C0, 1, -1, -1);
        checks++; if (cap_last[3] !== 1'b1 || cap_err[3] !== 1'b1) begin
            failures++; $display("FAIL no_rlast got=l%0b e%0b exp=l1 e1", cap_last[3], cap_err[3]);
        end
    endtask

    task automatic test_write();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h2000_0008;
        req_wdata = 32'hDEAD_BEEF; req_wstrb = 4'h3;
        tick();
        req_valid = 1'b0;
        checks++; if (axi.AWVALID !== 1'b1 || axi.WVALID !== 1'b1) begin
            failures++; $display("FAIL wr_valids got=%0b%0b exp=11", axi.AWVALID, axi.WVALID);
        end
        checks++; if (axi.AWADDR !== 32'h2000_0008 || axi.AWLEN !== 4'd0 || axi.AWBURST !== 2'b01) begin
            failures++; $display("FAIL wr_aw got=%h/%0d/%0d exp=20000008/0/1", axi.AWADDR, axi.AWLEN, axi.AWBURST);
        end
        checks++; if (axi.WDATA !== 32'hDEAD_BEEF || axi.WSTRB !== 4'h3 || axi.WLAST !== 1'b1) begin
            failures++; $display("FAIL wr_w got=%h/%h/%0b exp=deadbeef/3/1", axi.WDATA, axi.WSTRB, axi.WLAST);
        end
        axi.AWREADY = 1'b1;
        tick();
        axi.AWREADY = 1'b0;
        checks++; if (axi.AWVALID !== 1'b0 || axi.WVALID !== 1'b1) begin
            failures++; $display("FAIL wr_aw_drop got=%0b%0b exp=01", axi.AWVALID, axi.WVALID);
        end
        tick(); tick();
        axi.WREADY = 1'b1;
        tick();
        axi.WREADY = 1'b0;
        checks++; if (axi.WVALID !== 1'b0 || axi.BREADY !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++; $display("FAIL wr_w_drop got=w%0b b%0b r%0b exp=w0 b1 r0", axi.WVALID, axi.BREADY, rsp_valid);
        end
        axi.BVALID = 1'b1; axi.BRESP = 2'b00; axi.BID = '0;
        tick();
        axi.BVALID = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_last !== 1'b1 || rsp_err !== 1'b0) begin
            failures++; $display("FAIL wr_rsp got=v%0b l%0b e%0b exp=v1 l1 e0", rsp_valid, rsp_last, rsp_err);
        end
        checks++; if (req_ready !== 1'b1 || axi.BREADY !== 1'b0) begin
            failures++; $display("FAIL wr_idle got=rdy%0b bready%0b exp=rdy1 bready0", req_ready, axi.BREADY);
        end
    endtask

    task automatic test_write_same_cycle();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h3000_0004;
        req_wdata = 32'h1234_5678; req_wstrb = 4'hF;
        tick();
        req_valid = 1'b0;
        axi.AWREADY = 1'b1; axi.WREADY = 1'b1;
        tick();
        axi.AWREADY = 1'b0; axi.WREADY = 1'b0;
        checks++; if (axi.AWVALID !== 1'b0 || axi.WVALID !== 1'b0 || axi.BREADY !== 1'b1) begin
            failures++; $display("FAIL wr2_both got=aw%0b w%0b b%0b exp=aw0 w0 b1", axi.AWVALID, axi.WVALID, axi.BREADY);
        end
        axi.BVALID = 1'b1; axi.BRESP = 2'b10;
        tick();
        axi.BVALID = 1'b0; axi.BRESP = 2'b00;
        checks++; if (rsp_valid !== 1'b1 || rsp_last !== 1'b1 || rsp_err !== 1'b1) begin
            failures++; $display("FAIL wr2_bresp_err got=v%0b l%0b e%0b exp=v1 l1 e1", rsp_valid, rsp_last, rsp_err);
        end
    endtask

    task automatic test_write_zero_strb();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h4000_0000; req_wstrb = 4'h0;
        tick();
        req_valid = 1'b0;
        checks++; if (axi.AWVALID !== 1'b0 || axi.WVALID !== 1'b0) begin
            failures++; $display("FAIL zs_no_traffic got=%0b%0b exp=00", axi.AWVALID, axi.WVALID);
        end
        checks++; if (rsp_valid !== 1'b1 || rsp_last !== 1'b1 || rsp_err !== 1'b0) begin
            failures++; $display("FAIL zs_rsp got=v%0b l%0b e%0b exp=v1 l1 e0", rsp_valid, rsp_last, rsp_err);
        end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL zs_ready got=%0b exp=1", req_ready); end
    endtask

    task automatic test_ignore_rb_idle();
        axi.RVALID = 1'b1; axi.BVALID = 1'b1;
        tick(); tick();
        checks++; if (axi.RREADY !== 1'b0 || axi.BREADY !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++; $display("FAIL idle_ignore got=rr%0b br%0b v%0b exp=rr0 br0 v0", axi.RREADY, axi.BREADY, rsp_valid);
        end
        axi.RVALID = 1'b0; axi.BVALID = 1'b0;
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h5000_0000;
        tick();
        req_valid = 1'b0;
        axi.ARREADY = 1'b1;
        tick();
        axi.ARREADY = 1'b0;
        for (int i = 0; i < 2; i++) begin
            axi.RVALID = 1'b1; axi.RDATA = 32'hB0 + 32'(i); axi.RLAST = 1'b0;
            tick();
        end
        axi.RDATA = 32'hB2;
        rst = 1'b0;
        tick();
        checks++; if ({req_ready, rsp_valid, rsp_last, rsp_err, axi.ARVALID, axi.RREADY,
                       axi.AWVALID, axi.WVALID, axi.BREADY} !== 9'b0 ||
                      rsp_data !== 32'h0 || rsp_beat !== 4'd0) begin
            failures++; $display("FAIL mid_rst got=flags%09b d%h b%0d exp=0",
                {req_ready, rsp_valid, rsp_last, rsp_err, axi.ARVALID, axi.RREADY,
                 axi.AWVALID, axi.WVALID, axi.BREADY}, rsp_data, rsp_beat);
        end
        axi.RVALID = 1'b0;
        rst = 1'b1;
        tick();
        read_burst(32'h5000_0024, 1, -1, 3);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_valid[i] !== 1'b1 || cap_beat[i] !== 4'(i) || cap_data[i] !== 32'hA0 + 32'(i)) begin
                failures++; $display("FAIL post_rst_beat%0d got=v%0b b%0d d%h exp=v1 b%0d d%h", i,
                    cap_valid[i], cap_beat[i], cap_data[i], i, 32'hA0 + 32'(i));
            end
        end
        checks++; if (cap_araddr !== 32'h5000_0020 || cap_last[3] !== 1'b1 || cap_err[3] !== 1'b0) begin
            failures++; $display("FAIL post_rst_end got=a%h l%0b e%0b exp=a50000020 l1 e0",
                cap_araddr, cap_last[3], cap_err[3]);
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_read_rresp_err();
        test_read_early_rlast();
        test_write();
        test_write_same_cycle();
        test_write_zero_strb();
        test_ignore_rb_idle();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
